// File: rtl/peek_scanner.sv
// Walks a NoC peek port across the cores selected by a mask, reading a block of
// words per core and presenting each word on a ready/valid output.
module peek_scanner #(
    parameter int unsigned RN        = 16,
    parameter int unsigned PEEK_LAT  = 1,
    parameter int unsigned ADDR_STEP = 4,
    localparam int unsigned IDW      = (RN > 1) ? $clog2(RN) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [31:0]       base_addr,
    input  logic [15:0]       word_count,
    input  logic [RN-1:0]     core_mask,
    output logic [31:0]       peekAddress,
    output logic [IDW-1:0]    peekId,
    input  logic [31:0]       peekData,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [IDW-1:0]    out_core,
    output logic [31:0]       out_addr,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]     r_state;
    logic [31:0]    r_base;
    logic [15:0]    r_count;
    logic [RN-1:0]  r_mask;
    logic [31:0]    r_peek_addr;
    logic [IDW-1:0] r_peek_id;
    logic [15:0]    r_word_cnt;
    logic [2:0]     r_lat_cnt;
    logic           r_out_valid;
    logic [31:0]    r_out_data;
    logic [IDW-1:0] r_out_core;
    logic [31:0]    r_out_addr;

    logic           w_first_found;
    logic [IDW-1:0] w_first_id;
    logic           w_has_next;
    logic [IDW-1:0] w_next_id;
    logic           w_last_word;
    logic           w_lat_done;
    logic           w_handshake;

    // Lowest selected core of the mask presented at start.
    always_comb begin
        w_first_found = 1'b0;
        w_first_id    = '0;
        for (int unsigned i = 0; i < RN; i++) begin
            if (!w_first_found && core_mask[i]) begin
                w_first_found = 1'b1;
                w_first_id    = IDW'(i);
            end
        end
    end

    // Next selected core strictly above the one currently being peeked.
    always_comb begin
        w_has_next = 1'b0;
        w_next_id  = '0;
        for (int unsigned i = 0; i < RN; i++) begin
            if (!w_has_next && r_mask[i] && (i > 32'(r_peek_id))) begin
                w_has_next = 1'b1;
                w_next_id  = IDW'(i);
            end
        end
    end

    assign w_last_word = (r_word_cnt == (r_count - 16'd1));
    assign w_lat_done  = (r_lat_cnt == 3'(PEEK_LAT - 1));
    assign w_handshake = r_out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_count     <= '0;
            r_mask      <= '0;
            r_peek_addr <= '0;
            r_peek_id   <= '0;
            r_word_cnt  <= '0;
            r_lat_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_core  <= '0;
            r_out_addr  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!abort && start) begin
                        r_base      <= base_addr;
                        r_count     <= word_count;
                        r_mask      <= core_mask;
                        r_peek_addr <= base_addr;
                        r_word_cnt  <= '0;
                        r_lat_cnt   <= '0;
                        if ((word_count == 16'd0) || !w_first_found) begin
                            r_state <= S_DONE;
                        end else begin
                            r_peek_id <= w_first_id;
                            r_state   <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (abort) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end else if (w_lat_done) begin
                        r_out_data  <= peekData;
                        r_out_core  <= r_peek_id;
                        r_out_addr  <= r_peek_addr;
                        r_out_valid <= 1'b1;
                        r_state     <= S_OUT;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 3'd1;
                    end
                end
                S_OUT: begin
                    // Abort wins over a simultaneous handshake.
                    if (abort) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end else if (w_handshake) begin
                        r_out_valid <= 1'b0;
                        r_lat_cnt   <= '0;
                        if (!w_last_word) begin
                            r_peek_addr <= r_peek_addr + 32'(ADDR_STEP);
                            r_word_cnt  <= r_word_cnt + 16'd1;
                            r_state     <= S_WAIT;
                        end else if (w_has_next) begin
                            r_peek_id   <= w_next_id;
                            r_peek_addr <= r_base;
                            r_word_cnt  <= '0;
                            r_state     <= S_WAIT;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign peekAddress = r_peek_addr;
    assign peekId      = r_peek_id;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_core    = r_out_core;
    assign out_addr    = r_out_addr;
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);

endmodule

// File: tb/tb_peek_scanner.sv
// Directed bench for peek_scanner: scoreboard of expected (core, addr, data)
// words checked by a negedge monitor, plus directed control/timing checks.
module tb_peek_scanner;

    localparam int unsigned RN = 16;
    localparam int unsigned PL = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [31:0]   base_addr = '0;
    logic [15:0]   word_count = '0;
    logic [RN-1:0] core_mask = '0;
    logic [31:0]   peekAddress;
    logic [3:0]    peekId;
    logic [31:0]   peekData;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [31:0]   out_data;
    logic [3:0]    out_core;
    logic [31:0]   out_addr;
    logic          busy;
    logic          done;

    typedef struct {
        logic [3:0]  core;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];

    int checks = 0;
    int failures = 0;
    int hs = 0;
    int done_cnt = 0;
    bit valid_seen = 1'b0;
    logic [RN-1:0] cur_mask = '0;
    bit hold = 1'b0;
    logic [3:0]  h_core;
    logic [31:0] h_addr;
    logic [31:0] h_data;

    always #5 clk = ~clk;

    function automatic logic [31:0] ram(input logic [3:0] id, input logic [31:0] a);
        return {id, 28'h0} ^ (a * 32'h0001_9E37) ^ 32'h5A5A_0000;
    endfunction

    assign peekData = ram(peekId, peekAddress);

    peek_scanner #(.RN(RN), .PEEK_LAT(PL), .ADDR_STEP(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .base_addr(base_addr), .word_count(word_count), .core_mask(core_mask),
        .peekAddress(peekAddress), .peekId(peekId), .peekData(peekData),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_core(out_core), .out_addr(out_addr), .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [RN-1:0] m, input logic [31:0] b, input logic [15:0] c);
        for (int k = 0; k < int'(RN); k++) begin
            if (m[k]) begin
                for (int w = 0; w < int'(c); w++) begin
                    exp_t e;
                    e.core = 4'(k);
                    e.addr = b + 32'(w * 4);
                    e.data = ram(e.core, e.addr);
                    q.push_back(e);
                end
            end
        end
    endtask

    // Drives a one-cycle start; returns just after the sampling edge.
    task automatic run_start(input logic [RN-1:0] m, input logic [31:0] b,
                             input logic [15:0] c, input bit do_push);
        core_mask  = m;
        base_addr  = b;
        word_count = c;
        cur_mask   = m;
        hs         = 0;
        done_cnt   = 0;
        valid_seen = 1'b0;
        if (do_push) push_exp(m, b, c);
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_done(input int n0, input bit rnd, output int n);
        n = n0;
        while (!done && n < 400) begin
            cyc();
            n++;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
        end
        if (!done) chk("done_timeout", 32'(done), 32'd1);
        out_ready = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", out_data, h_data);
                chk("hold_addr", out_addr, h_addr);
                chk("hold_core", 32'(out_core), 32'(h_core));
            end
            hold   = out_valid && !out_ready && !abort;
            h_core = out_core;
            h_addr = out_addr;
            h_data = out_data;
            if (done) done_cnt++;
            if (out_valid) valid_seen = 1'b1;
            if (busy && !done) chk("peekId_in_mask", 32'(cur_mask[peekId]), 32'd1);
            if (out_valid && out_ready && !abort) begin
                hs++;
                if (q.size() == 0) begin
                    chk("extra_word", 32'(out_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("word_core", 32'(out_core), 32'(e.core));
                    chk("word_addr", out_addr, e.addr);
                    chk("word_data", out_data, e.data);
                end
            end
        end
    end

    initial begin
        int n;

        // Reset state
        repeat (3) cyc();
        chk("rst_peekAddress", peekAddress, 32'd0);
        chk("rst_peekId", 32'(peekId), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_core", 32'(out_core), 32'd0);
        chk("rst_out_addr", out_addr, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(negedge clk); #1 rst_n = 1'b1;
        cyc();

        // Two cores, two words each, ready tied high
        run_start(16'h0005, 32'h100, 16'd2, 1'b1);
        chk("A_busy", 32'(busy), 32'd1);
        chk("A_valid_early", 32'(out_valid), 32'd0);
        chk("A_peekAddr", peekAddress, 32'h100);
        cyc();
        chk("A_valid_first", 32'(out_valid), 32'd1);
        wait_done(1, 1'b0, n);
        chk("A_done_cycle", 32'(n), 32'(4 * (PL + 1)));
        cyc();
        chk("A_idle", 32'(busy), 32'd0);
        chk("A_done_cnt", 32'(done_cnt), 32'd1);
        chk("A_hs", 32'(hs), 32'd4);
        chk("A_q_empty", 32'(q.size()), 32'd0);

        // Random backpressure across four cores
        run_start(16'h8421, 32'h0000_1000, 16'd3, 1'b1);
        start = 1'b1;
        base_addr = 32'hDEAD_0000;
        cyc();
        start = 1'b0;
        wait_done(1, 1'b1, n);
        cyc();
        chk("B_hs", 32'(hs), 32'd12);
        chk("B_done_cnt", 32'(done_cnt), 32'd1);
        chk("B_q_empty", 32'(q.size()), 32'd0);

        // Empty scans
        run_start(16'h0005, 32'h100, 16'd0, 1'b1);
        chk("C0_done", 32'(done), 32'd1);
        chk("C0_busy", 32'(busy), 32'd1);
        cyc();
        chk("C0_done_end", 32'(done), 32'd0);
        chk("C0_busy_end", 32'(busy), 32'd0);
        chk("C0_no_valid", 32'(valid_seen), 32'd0);
        run_start(16'h0000, 32'h100, 16'd2, 1'b1);
        chk("C1_done", 32'(done), 32'd1);
        chk("C1_busy", 32'(busy), 32'd1);
        cyc();
        chk("C1_busy_end", 32'(busy), 32'd0);
        chk("C1_no_valid", 32'(valid_seen), 32'd0);
        chk("C1_done_cnt", 32'(done_cnt), 32'd1);

        // Address wrap
        run_start(16'h0001, 32'hFFFF_FFF8, 16'd3, 1'b1);
        wait_done(0, 1'b0, n);
        cyc();
        chk("D_hs", 32'(hs), 32'd3);
        chk("D_q_empty", 32'(q.size()), 32'd0);

        // Abort during the second OUT, then a full rescan
        begin
            exp_t e;
            e.core = 4'd0;
            e.addr = 32'h200;
            e.data = ram(4'd0, 32'h200);
            q.push_back(e);
        end
        run_start(16'h0005, 32'h200, 16'd2, 1'b0);
        cyc();
        cyc();
        cyc();
        chk("E_second_valid", 32'(out_valid), 32'd1);
        chk("E_second_addr", out_addr, 32'h204);
        abort = 1'b1;
        cyc();
        chk("E_abort_valid", 32'(out_valid), 32'd0);
        chk("E_abort_busy", 32'(busy), 32'd0);
        abort = 1'b0;
        cyc();
        chk("E_no_done", 32'(done_cnt), 32'd0);
        chk("E_hs", 32'(hs), 32'd1);
        chk("E_q_empty", 32'(q.size()), 32'd0);
        run_start(16'h0005, 32'h300, 16'd2, 1'b1);
        chk("E2_first_id", 32'(peekId), 32'd0);
        wait_done(0, 1'b0, n);
        cyc();
        chk("E2_hs", 32'(hs), 32'd4);
        chk("E2_done_cnt", 32'(done_cnt), 32'd1);

        // Reset mid-WAIT with start held high
        run_start(16'h0006, 32'h400, 16'd2, 1'b1);
        start = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("F_rst_peekAddress", peekAddress, 32'd0);
        chk("F_rst_peekId", 32'(peekId), 32'd0);
        chk("F_rst_busy", 32'(busy), 32'd0);
        chk("F_rst_out_valid", 32'(out_valid), 32'd0);
        chk("F_rst_done", 32'(done), 32'd0);
        q.delete();
        core_mask  = 16'h0010;
        base_addr  = 32'h500;
        word_count = 16'd1;
        cur_mask   = 16'h0010;
        push_exp(16'h0010, 32'h500, 16'd1);
        hs = 0;
        done_cnt = 0;
        @(negedge clk); #1 rst_n = 1'b1;
        cyc();
        start = 1'b0;
        chk("F_busy", 32'(busy), 32'd1);
        chk("F_peekId", 32'(peekId), 32'd4);
        chk("F_peekAddress", peekAddress, 32'h500);
        wait_done(0, 1'b0, n);
        cyc();
        chk("F_hs", 32'(hs), 32'd1);
        chk("F_done_cnt", 32'(done_cnt), 32'd1);
        chk("F_q_empty", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/peek_scanner.md
PEEK_SCANNER -- requirements
Module: peek_scanner

Interface
REQ-001 SHALL have parameter RN, default 16: number of cores, peekId width $clog2(RN).
REQ-002 SHALL have parameter PEEK_LAT, default 1 (range 1..7): cycles from peekAddress/peekId change to valid peekData.
REQ-003 SHALL have parameter ADDR_STEP, default 4: peekAddress increment per word.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  begin scan; sampled in IDLE only.
REQ-007 SHALL have port abort  input  1  terminate scan.
REQ-008 SHALL have port base_addr  input  32  first peek address per core.
REQ-009 SHALL have port word_count  input  16  words read per core.
REQ-010 SHALL have port core_mask  input  RN  bit k set = scan core k.
REQ-011 SHALL have port peekAddress  output  32  registered address to NoC peek port.
REQ-012 SHALL have port peekId  output  $clog2(RN)  registered core id to NoC peek port.
REQ-013 SHALL have port peekData  input  32  data returned by NoC peek port.
REQ-014 SHALL have port out_valid  output  1  out_* fields hold a word.
REQ-015 SHALL have port out_ready  input  1  consumer accepts word.
REQ-016 SHALL have port out_data  output  32  captured peekData.
REQ-017 SHALL have port out_core  output  $clog2(RN)  core id of out_data.
REQ-018 SHALL have port out_addr  output  32  address of out_data.
REQ-019 SHALL have port busy  output  1  high in any state except IDLE.
REQ-020 SHALL have port done  output  1  one-cycle pulse at normal scan end.

Function
REQ-021 SHALL implement states IDLE, WAIT, OUT, DONE.
REQ-022 IDLE, start=1: SHALL latch base_addr, word_count, core_mask; load peekId = lowest set mask bit, peekAddress = base_addr, word counter = 0; go to WAIT.
REQ-023 IDLE, start=1 with word_count=0 or core_mask=0: SHALL go to DONE, no peek cycle, no output word.
REQ-024 WAIT SHALL hold peekId/peekAddress stable for PEEK_LAT cycles, then capture peekData into out_data, copy peekId/peekAddress into out_core/out_addr, set out_valid, go to OUT.
REQ-025 OUT SHALL hold out_valid and all out_* stable until out_valid & out_ready on an edge.
REQ-026 On handshake, counter < word_count-1: SHALL add ADDR_STEP to peekAddress (mod 2^32), increment counter, go to WAIT.
REQ-027 On handshake, last word of core: SHALL move peekId to next higher set mask bit, reload peekAddress = latched base, clear counter, go to WAIT; if no higher bit, go to DONE.
REQ-028 out_valid SHALL drop in the cycle after a handshake edge unless a new word is captured that edge (not possible for PEEK_LAT >= 1).
REQ-029 Word order SHALL be core-major ascending id, address-ascending within core; masked cores SHALL never appear on peekId.
REQ-030 DONE SHALL assert done for exactly one cycle, then go to IDLE.
REQ-031 start while busy SHALL be ignored; latched parameters SHALL not change mid-scan.
REQ-032 abort=1 in WAIT/OUT/DONE SHALL go to IDLE next edge, clear out_valid, no done pulse; abort has priority over handshake; abort in IDLE SHALL have priority over start.
REQ-033 Throughput SHALL be one word per PEEK_LAT+1 cycles with out_ready tied high.
REQ-034 peekAddress SHALL wrap 0xFFFFFFFC+4 -> 0x00000000 without error.

Reset
REQ-035 rst_n low SHALL immediately force IDLE, peekAddress=0, peekId=0, out_valid=0, out_data=0, out_core=0, out_addr=0, busy=0, done=0, counter=0.
REQ-036 Reset mid-scan SHALL discard scan; first edge after release SHALL be IDLE behaviour.

Verification
REQ-037 mask=16'h0005, base=0x100, count=2, PEEK_LAT=1, out_ready=1 -> words (core,addr) (0,0x100),(0,0x104),(2,0x100),(2,0x104); out_valid first high 2 cycles after start; done pulse once; core 1 never on peekId.
REQ-038 count=3, out_ready toggling random -> out_* stable while valid & !ready; exactly 3*popcount(mask) handshakes; data matches per-core RAM model.
REQ-039 count=0 or mask=0 -> done one cycle after start, out_valid never high, busy high exactly 1 cycle.
REQ-040 base=0xFFFFFFF8, count=3, mask=1 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
REQ-041 abort during second OUT -> out_valid low next cycle, no done, IDLE; subsequent start runs full scan from first core.
REQ-042 rst_n asserted mid-WAIT, start held high -> all outputs zero asynchronously; after release, new scan begins from latched current inputs.
